// File: rtl/nn_pkg.sv
// Shared types and constants for the perceptron network sequencer.
package nn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_PARAM,
        CHECK,
        LOAD_INPUT,
        COMPUTE,
        OUTPUT
    } nn_state_e;

    // Datapath selector encodings
    localparam logic [1:0] SEL_PARAM   = 2'd0;
    localparam logic [1:0] SEL_INPUT   = 2'd1;
    localparam logic [1:0] SEL_COMPUTE = 2'd2;
    localparam logic [1:0] SEL_HOLD    = 2'd3;

    localparam int unsigned N_NEURONS         = 4;
    localparam int unsigned PARAMS_PER_NEURON = 6;
    localparam int unsigned N_PARAMS          = N_NEURONS * PARAMS_PER_NEURON;
    localparam int unsigned N_INPUTS          = N_NEURONS;

endpackage

// File: rtl/nn_byte_loader.sv
// Byte loader: handshake qualification and write-address counter shared by
// the parameter and input load phases. The counter is held at zero whenever
// the owning phase is inactive, so every entry starts from address 0.
module nn_byte_loader #(
    parameter int unsigned N_BYTES = 24,
    parameter int unsigned AW      = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          active,
    input  logic          in_valid,
    input  logic          in_ready,
    output logic          we,
    output logic [AW-1:0] addr,
    output logic          last
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(N_BYTES - 1);

    logic [AW-1:0] cnt;

    assign we   = active & in_valid & in_ready;
    assign addr = cnt;
    assign last = we & (cnt == LAST_ADDR);

    // Advance on each accepted byte; hold on the final byte instead of wrapping
    always_ff @(posedge clk) begin
        if (reset || !active) begin
            cnt <= '0;
        end else if (we && !last) begin
            cnt <= cnt + AW'(1);
        end
    end

endmodule

// File: rtl/nn_sequencer.sv
// Sequencer for the 4-neuron perceptron network: loads 24 parameter bytes
// and 4 input bytes from a valid/ready byte stream, runs N_LAYERS feedback
// passes and presents the result with an output handshake.
// Optional feature: define NN_SEQ_CHECKSUM_EN to require a modulo-256
// checksum byte after the parameter set (CHECK state, sticky error flag).
module nn_sequencer
    import nn_pkg::*;
#(
    parameter int unsigned N_LAYERS      = 2,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       reload,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic [1:0] sel,
    output logic       param_we,
    output logic [4:0] param_addr,
    output logic [7:0] param_wdata,
    output logic       inp_we,
    output logic [1:0] inp_addr,
    output logic [7:0] inp_wdata,
    output logic       layer_capture,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       params_ok,
    output logic       error
);

    localparam logic [3:0] LAYER_LAST  = 4'(N_LAYERS - 1);
    localparam logic [2:0] SETTLE_LAST = 3'(SETTLE_CYCLES - 1);

    nn_state_e  state;
    logic [3:0] lcnt;
    logic [2:0] scnt;
    logic       p_last;
    logic       i_last;

    nn_byte_loader #(
        .N_BYTES (N_PARAMS),
        .AW      (5)
    ) u_param_loader (
        .clk      (clk),
        .reset    (reset),
        .active   (state == LOAD_PARAM),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .we       (param_we),
        .addr     (param_addr),
        .last     (p_last)
    );

    nn_byte_loader #(
        .N_BYTES (N_INPUTS),
        .AW      (2)
    ) u_input_loader (
        .clk      (clk),
        .reset    (reset),
        .active   (state == LOAD_INPUT),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .we       (inp_we),
        .addr     (inp_addr),
        .last     (i_last)
    );

    assign param_wdata   = in_data;
    assign inp_wdata     = in_data;
    assign layer_capture = (state == COMPUTE) && (scnt == SETTLE_LAST);

`ifdef NN_SEQ_CHECKSUM_EN
    logic [7:0] csum;
    logic       err_q;
    assign error = err_q;
`else
    assign error = 1'b0;
`endif

    // Main control FSM; registered outputs are updated together with the state
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sel       <= SEL_HOLD;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            params_ok <= 1'b0;
            lcnt      <= '0;
            scnt      <= '0;
`ifdef NN_SEQ_CHECKSUM_EN
            csum      <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
`ifdef NN_SEQ_CHECKSUM_EN
                        err_q <= 1'b0;
                        csum  <= '0;
`endif
                        busy     <= 1'b1;
                        in_ready <= 1'b1;
                        if (reload || !params_ok) begin
                            state     <= LOAD_PARAM;
                            sel       <= SEL_PARAM;
                            params_ok <= 1'b0;
                        end else begin
                            state <= LOAD_INPUT;
                            sel   <= SEL_INPUT;
                        end
                    end
                end

                LOAD_PARAM: begin
`ifdef NN_SEQ_CHECKSUM_EN
                    if (param_we) begin
                        csum <= csum + in_data;
                    end
                    if (p_last) begin
                        state <= CHECK;
                    end
`else
                    if (p_last) begin
                        state     <= LOAD_INPUT;
                        sel       <= SEL_INPUT;
                        params_ok <= 1'b1;
                    end
`endif
                end

                CHECK: begin
`ifdef NN_SEQ_CHECKSUM_EN
                    if (in_valid && in_ready) begin
                        if (in_data == csum) begin
                            state     <= LOAD_INPUT;
                            sel       <= SEL_INPUT;
                            params_ok <= 1'b1;
                        end else begin
                            state    <= IDLE;
                            sel      <= SEL_HOLD;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            err_q    <= 1'b1;
                        end
                    end
`else
                    state     <= IDLE;
                    sel       <= SEL_HOLD;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
`endif
                end

                LOAD_INPUT: begin
                    if (i_last) begin
                        state    <= COMPUTE;
                        sel      <= SEL_COMPUTE;
                        in_ready <= 1'b0;
                        lcnt     <= '0;
                        scnt     <= '0;
                    end
                end

                COMPUTE: begin
                    if (scnt == SETTLE_LAST) begin
                        if (lcnt == LAYER_LAST) begin
                            state     <= OUTPUT;
                            sel       <= SEL_HOLD;
                            out_valid <= 1'b1;
                        end else begin
                            lcnt <= lcnt + 4'd1;
                            scnt <= '0;
                        end
                    end else begin
                        scnt <= scnt + 3'd1;
                    end
                end

                OUTPUT: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    sel       <= SEL_HOLD;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/nn_sequencer.md
Name: nn_sequencer

Overview:
- Controller sequencing the 4-neuron perceptron network.
- Accepts a byte stream on a valid/ready interface, writes 24 parameter bytes (4 weights, bias and threshold per neuron) and then 4 input bytes into the datapath registers.
- Runs N_LAYERS feedback passes through the perceptrons, then presents the result with an output handshake.
- Sits between the host byte interface and the shift/parameter registers; replaces the free-running `changes`-driven mode machine.

Parameters:
- N_LAYERS, 2, number of compute passes per inference (1..15).
- SETTLE_CYCLES, 1, cycles to wait after each pass starts before capturing perceptron outputs (1..7).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin an inference; honoured only in IDLE
- reload  in  1  sampled with start; 1 forces a parameter reload
- in_valid  in  1  host byte valid
- in_data  in  8  host byte
- in_ready  out  1  sequencer accepts the byte this cycle
- sel  out  2  datapath selector: 0 = LOAD_PARAM, 1 = LOAD_INPUT, 2 = COMPUTE, 3 = HOLD
- param_we  out  1  parameter write strobe
- param_addr  out  5  parameter index 0..23, equal to neuron*6 + k (k: 0..3 weights, 4 bias, 5 threshold)
- param_wdata  out  8  parameter byte
- inp_we  out  1  input-register write strobe
- inp_addr  out  2  input index 0..3
- inp_wdata  out  8  input byte
- layer_capture  out  1  one-cycle strobe; datapath latches neuron outputs back into its inputs
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts the result
- busy  out  1  high in every state except IDLE
- params_ok  out  1  a full parameter set is loaded
- error  out  1  sticky error flag; cleared by reset or by an accepted start

Behaviour:
- Reset (synchronous, active-high, dominates all inputs): state = IDLE; all counters = 0; sel = 3; every strobe = 0; in_ready = 0; out_valid = 0; busy = 0; params_ok = 0; error = 0.
- Reset asserted mid-load or mid-compute aborts the operation and clears params_ok.
- IDLE, start = 1:
  - reload = 1 or params_ok = 0: go to LOAD_PARAM and clear params_ok.
  - Otherwise: go to LOAD_INPUT.
  - start in any other state is ignored.
- LOAD_PARAM: sel = 0; in_ready = 1.
  - On each handshake (in_valid & in_ready), in the same cycle: param_we = 1, param_addr = pcnt, param_wdata = in_data; pcnt increments.
  - After the handshake with pcnt = 23: go to LOAD_INPUT, set params_ok = 1 (or go to CHECK when the optional feature is compiled in).
  - in_valid = 0 stalls without limit.
- LOAD_INPUT: sel = 1; in_ready = 1.
  - On each handshake: inp_we = 1, inp_addr = icnt, inp_wdata = in_data.
  - After icnt = 3: go to COMPUTE with scnt = 0 and lcnt = 0.
- COMPUTE: sel = 2; in_ready = 0.
  - scnt counts up to SETTLE_CYCLES-1; in the cycle where scnt = SETTLE_CYCLES-1, layer_capture = 1.
  - After the capture: if lcnt = N_LAYERS-1, go to OUTPUT; otherwise lcnt increments and scnt = 0.
  - Latency from the last input handshake to out_valid = N_LAYERS*SETTLE_CYCLES + 1 cycles (N_LAYERS=2, SETTLE_CYCLES=1: 3 cycles).
- OUTPUT: sel = 3; out_valid = 1 and held until out_ready = 1.
  - On the handshake: go to IDLE. A start in the same cycle is ignored.
- Counters: pcnt is 5 bits, icnt 2 bits, lcnt 4 bits, scnt 3 bits. All clear on entry to their state; none wraps inside a state.
- Strobes are combinational from the handshake and state; every other output is registered.
- No more than one of param_we, inp_we and layer_capture is ever high in a cycle.

Optional Feature:
- Macro: NN_SEQ_CHECKSUM_EN.
- Defined:
  - After parameter byte 23, state CHECK accepts one additional byte.
  - If that byte equals the 8-bit modulo-256 sum of the 24 parameter bytes: params_ok = 1, go to LOAD_INPUT.
  - Otherwise: error = 1, params_ok stays 0, go to IDLE.
  - CHECK drives sel = 0, in_ready = 1, param_we = 0.
- Undefined: no CHECK state and no checksum register; error is tied to 0.

Decomposition:
- Package nn_pkg:
  - state enum (IDLE, LOAD_PARAM, CHECK, LOAD_INPUT, COMPUTE, OUTPUT).
  - sel encodings SEL_PARAM = 0, SEL_INPUT = 1, SEL_COMPUTE = 2, SEL_HOLD = 3.
  - constants N_NEURONS = 4, PARAMS_PER_NEURON = 6, N_PARAMS = 24.
- One sub-module, nn_byte_loader: shared handshake and counter logic for the parameter and input load phases, parameterised by byte count, producing we, addr and a last flag.

Test Plan:
- Cold inference: reset, start with reload = 0, send params 1..24 then inputs 0x10, 0x20, 0x30, 0x40.
  - param_addr/param_wdata sequence 0/1 .. 23/24; inp_addr 0..3 with matching data; params_ok rises after byte 24.
  - layer_capture pulses exactly 2 times; out_valid 3 cycles after the last input.
- Warm inference: second start with reload = 0.
  - Sequencer goes straight to LOAD_INPUT; no param_we.
  - reload = 1 forces all 24 parameter writes again.
- Backpressure: in_valid toggles every other cycle during the loads, and out_ready is held low for 5 cycles.
  - Writes occur only on handshake cycles; out_valid stays high until out_ready.
- Reset mid-load: assert reset after 10 parameter bytes.
  - All outputs return to reset values and params_ok = 0.
  - The next start reloads from param_addr 0.
- Ignored start: pulse start while in COMPUTE and in the same cycle as the out_ready handshake.
  - No state change; IDLE is reached with busy = 0.
- NN_SEQ_CHECKSUM_EN: send params 1..24 followed by checksum 0x2C.
  - Correct checksum: params_ok = 1.
  - Checksum 0x2D instead: error = 1, params_ok = 0, IDLE.
